bsg_upstream_out_serializer: RTL and testbench
==============================================

// Module: bsg_upstream_out_serializer
// PURPOSE
//  Parametrised upstream link transmitter. Accepts one CORE_W-bit word from the core
//  and serialises it over CHANNELS parallel CH_W-bit link channels in BEATS cycles.
//  Token-credit flow control: one credit is consumed per word, one is returned per io_token.
//  Generalises the fixed 64b/2x8b output path to any width, channel count and credit depth.
// PARAMETERS
//  CORE_W    64  core word width; must be a multiple of CHANNELS*CH_W
//  CHANNELS  2   number of link channels
//  CH_W      8   bits per channel per beat
//  CREDITS   4   link credit depth; counter reset value and saturation limit
//  CNT_W     7   width of the sent_cnt/finish_cnt counters (wrap mod 2^CNT_W)
//  derived: BEATS = CORE_W/(CHANNELS*CH_W) (default 4); CR_W = $clog2(CREDITS+1)
// PORTS
//  clk              in   1                clock
//  rst              in   1                synchronous reset, active-high
//  core_data_in     in   CORE_W           word to send
//  core_valid_in    in   1                core offers a word
//  core_ready_out   out  1                block accepts the word this cycle
//  io_token         in   1                credit return, one credit per cycle high
//  io_valid_out     out  1                link beat valid
//  io_data_out      out  CHANNELS*CH_W    channel c at [c*CH_W +: CH_W]
//  sent_cnt         out  CNT_W            words started
//  finish_cnt       out  CNT_W            words whose last beat has been sent
//  credit_cnt       out  CR_W             available credits
//  credit_err       out  1                sticky: token received with credits == CREDITS
// BEHAVIOUR
//  Reset: io_valid_out=0, io_data_out=0, core_ready_out=0 in the reset cycle, sent_cnt=0,
//   finish_cnt=0, credit_cnt=CREDITS, credit_err=0, FSM=IDLE, step=0. Reset mid-word
//   aborts the word; no further beats, no finish_cnt increment.
//  FSM IDLE: core_ready_out = (credit_cnt != 0). On core_valid_in & core_ready_out:
//   register the word, sent_cnt+1, consume one credit, step=0, go to SEND.
//  FSM SEND: core_ready_out=0. Each cycle: io_valid_out=1 and channel c carries word bits
//   [(step*CHANNELS+c)*CH_W +: CH_W]; step+1. On step==BEATS-1: finish_cnt+1, go to IDLE.
//  Latency: accept at cycle t -> beats at t+1..t+BEATS; earliest next accept at t+BEATS+1
//   (one idle cycle between words). io_valid_out=0 and io_data_out holds last beat in IDLE.
//  Beats are registered outputs; the link does not stall once SEND has begun.
//  Credits: token only -> +1; accept only -> -1; both same cycle -> unchanged.
//   Token with credit_cnt==CREDITS and no accept: count saturates, credit_err set (sticky
//   until rst). Accept is impossible at credit_cnt==0; core_valid_in then simply waits.
//  Counters wrap modulo 2^CNT_W (127 -> 0 at default).
//  BEATS==1 legal: SEND lasts one cycle, sent/finish increment on consecutive cycles.
// CONFIGURATION
//  BSG_UPOUT_PARITY_EN defined: adds output io_parity_out [CHANNELS]; bit c = even parity
//   (XOR) of channel c's current io_data_out slice, registered with it; 0 at reset.
//  Not defined: port absent; no parity logic; all other behaviour identical.
// TESTING
//  T1 reset, then word 0x0706050403020100 valid -> ready=1; beats io_data_out = 0x0100,
//     0x0302, 0x0504, 0x0706 on the 4 following cycles; sent_cnt=1, finish_cnt=1, credit=3.
//  T2 core_valid held, no tokens, 5 words offered -> exactly 4 accepted, ready=0 after the
//     4th; one io_token -> 5th accepted the next IDLE cycle; credit_cnt returns to 0.
//  T3 io_token high on the same cycle as an accept with credit_cnt=2 -> credit_cnt stays 2.
//  T4 io_token pulsed with credit_cnt=4 in IDLE -> credit_cnt stays 4, credit_err=1 until rst.
//  T5 rst asserted during beat 2 of a word -> next cycle io_valid_out=0, credit_cnt=4,
//     finish_cnt=0; a new word afterwards starts at beat 0.
//  T6 PARITY_EN, beat 0x0100 -> io_parity_out=2'b10; 128 words -> sent_cnt wraps to 0.

Source files
------------

// File: rtl/bsg_upstream_out_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : bsg_upstream_out_serializer_if                                |
// | Purpose    : Core-side handshake and link-side beat bus of the upstream    |
// |              serializer, bundled as one interface.                         |
// | Signals    : core_data_in   [CORE_W]        word offered by the core       |
// |              core_valid_in                  core offers a word             |
// |              core_ready_out                 serializer accepts the word    |
// |              io_token                       one link credit returned       |
// |              io_valid_out                   link beat valid                |
// |              io_data_out    [CHANNELS*CH_W] channel c at [c*CH_W +: CH_W]  |
// |              io_parity_out  [CHANNELS]      only with BSG_UPOUT_PARITY_EN  |
// | Modports   : slave  - serializer view                                      |
// |              master - core/link environment view                           |
// | Config     : BSG_UPOUT_PARITY_EN adds io_parity_out                        |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
interface bsg_upstream_out_serializer_if #(
  parameter int CORE_W   = 64,
  parameter int CHANNELS = 2,
  parameter int CH_W     = 8
);
  logic [CORE_W-1:0]        core_data_in;
  logic                     core_valid_in;
  logic                     core_ready_out;
  logic                     io_token;
  logic                     io_valid_out;
  logic [CHANNELS*CH_W-1:0] io_data_out;
`ifdef BSG_UPOUT_PARITY_EN
  logic [CHANNELS-1:0]      io_parity_out;
`endif

  modport slave (
    input  core_data_in,
    input  core_valid_in,
    input  io_token,
    output core_ready_out,
    output io_valid_out,
    output io_data_out
`ifdef BSG_UPOUT_PARITY_EN
    , output io_parity_out
`endif
  );

  modport master (
    output core_data_in,
    output core_valid_in,
    output io_token,
    input  core_ready_out,
    input  io_valid_out,
    input  io_data_out
`ifdef BSG_UPOUT_PARITY_EN
    , input io_parity_out
`endif
  );
endinterface
`default_nettype wire

// File: rtl/bsg_upstream_out_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : bsg_upstream_out_serializer                                   |
// | Purpose    : Upstream link transmitter. Takes one CORE_W-bit word from the |
// |              core and sends it over CHANNELS x CH_W-bit link channels in   |
// |              BEATS consecutive cycles, gated by token credits.             |
// | Ports      : clk, rst (synchronous, active-high)                           |
// |              link       - bsg_upstream_out_serializer_if.slave             |
// |              sent_cnt   [CNT_W]  words started (wraps)                     |
// |              finish_cnt [CNT_W]  words fully sent (wraps)                  |
// |              credit_cnt [CR_W]   available credits                         |
// |              credit_err          sticky token-overflow flag                |
// | Config     : BSG_UPOUT_PARITY_EN adds registered per-channel even parity   |
// |              on link.io_parity_out                                         |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module bsg_upstream_out_serializer #(
  parameter  int CORE_W   = 64,
  parameter  int CHANNELS = 2,
  parameter  int CH_W     = 8,
  parameter  int CREDITS  = 4,
  parameter  int CNT_W    = 7,
  localparam int CR_W     = $clog2(CREDITS + 1)
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  bsg_upstream_out_serializer_if.slave link,
  output logic [CNT_W-1:0]          sent_cnt,
  output logic [CNT_W-1:0]          finish_cnt,
  output logic [CR_W-1:0]           credit_cnt,
  output logic                      credit_err
);

  localparam int BEAT_W = CHANNELS * CH_W;
  localparam int BEATS  = CORE_W / BEAT_W;
  localparam int STEP_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(BEATS - 1);
  localparam logic [CR_W-1:0]   CREDITS_MAX = CR_W'(CREDITS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_n;
  logic [STEP_W-1:0]   step_q, step_n;
  logic [CORE_W-1:0]   word_q, word_n;
  logic [BEAT_W-1:0]   data_q, data_n;
  logic                valid_q, valid_n;
  logic [CNT_W-1:0]    sent_n, finish_n;
  logic [CR_W-1:0]     credit_n;
  logic                err_n;
  logic                ready;
  logic                accept;
  logic [STEP_W-1:0]   step_inc;

  // ready is forced low while rst is held so nothing is accepted in the reset cycle
  assign ready    = (state_q == IDLE) && (credit_cnt != '0) && !rst;
  assign accept   = link.core_valid_in && ready;
  assign step_inc = step_q + STEP_W'(1);

  // The beat register is loaded on the accept edge, so beat 0 is already on the
  // link during the first SEND cycle; each SEND cycle preloads the following beat.
  always_comb begin
    state_n  = state_q;
    step_n   = step_q;
    word_n   = word_q;
    data_n   = data_q;
    valid_n  = 1'b0;
    sent_n   = sent_cnt;
    finish_n = finish_cnt;
    case (state_q)
      IDLE: begin
        if (accept) begin
          word_n  = link.core_data_in;
          data_n  = link.core_data_in[BEAT_W-1:0];
          valid_n = 1'b1;
          step_n  = '0;
          sent_n  = sent_cnt + CNT_W'(1);
          state_n = SEND;
        end
      end
      SEND: begin
        if (step_q == LAST_STEP) begin
          finish_n = finish_cnt + CNT_W'(1);
          step_n   = '0;
          state_n  = IDLE;
        end else begin
          step_n  = step_inc;
          data_n  = word_q[int'(step_inc) * BEAT_W +: BEAT_W];
          valid_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Simultaneous accept and token cancel out; an overflowing token saturates.
  always_comb begin
    credit_n = credit_cnt;
    err_n    = credit_err;
    if (link.io_token && !accept) begin
      if (credit_cnt == CREDITS_MAX) begin
        err_n = 1'b1;
      end else begin
        credit_n = credit_cnt + CR_W'(1);
      end
    end else if (accept && !link.io_token) begin
      credit_n = credit_cnt - CR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= '0;
      word_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sent_cnt   <= '0;
      finish_cnt <= '0;
      credit_cnt <= CREDITS_MAX;
      credit_err <= 1'b0;
    end else begin
      state_q    <= state_n;
      step_q     <= step_n;
      word_q     <= word_n;
      data_q     <= data_n;
      valid_q    <= valid_n;
      sent_cnt   <= sent_n;
      finish_cnt <= finish_n;
      credit_cnt <= credit_n;
      credit_err <= err_n;
    end
  end

  assign link.core_ready_out = ready;
  assign link.io_valid_out   = valid_q;
  assign link.io_data_out    = data_q;

`ifdef BSG_UPOUT_PARITY_EN
  logic [CHANNELS-1:0] parity_n;
  logic [CHANNELS-1:0] parity_q;

  // Parity is computed from the next beat so it stays aligned with io_data_out.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_parity
    assign parity_n[c] = ^data_n[c*CH_W +: CH_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= '0;
    end else begin
      parity_q <= parity_n;
    end
  end

  assign link.io_parity_out = parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_upstream_out_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_bsg_upstream_out_serializer                                |
// | Purpose    : Self-checking bench for bsg_upstream_out_serializer using a   |
// |              queue-based reference model of the beat stream and credits.   |
// | Config     : BSG_UPOUT_PARITY_EN also checks io_parity_out                 |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_bsg_upstream_out_serializer;

  localparam int CORE_W   = 64;
  localparam int CHANNELS = 2;
  localparam int CH_W     = 8;
  localparam int CREDITS  = 4;
  localparam int CNT_W    = 7;
  localparam int CR_W     = 3;
  localparam int BEAT_W   = CHANNELS * CH_W;
  localparam int BEATS    = CORE_W / BEAT_W;

  logic clk = 1'b0;
  logic rst;
  logic [CNT_W-1:0] sent_cnt;
  logic [CNT_W-1:0] finish_cnt;
  logic [CR_W-1:0]  credit_cnt;
  logic             credit_err;

  always #5 clk = ~clk;

  bsg_upstream_out_serializer_if #(
    .CORE_W  (CORE_W),
    .CHANNELS(CHANNELS),
    .CH_W    (CH_W)
  ) link_if ();

  bsg_upstream_out_serializer #(
    .CORE_W  (CORE_W),
    .CHANNELS(CHANNELS),
    .CH_W    (CH_W),
    .CREDITS (CREDITS),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .link      (link_if),
    .sent_cnt  (sent_cnt),
    .finish_cnt(finish_cnt),
    .credit_cnt(credit_cnt),
    .credit_err(credit_err)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model: pending beats in order, plus plain integer bookkeeping.
  logic [BEAT_W-1:0] exp_q[$];
  logic [BEAT_W-1:0] m_last;
  int                m_credits;
  int                m_sent;
  int                m_fin;
  bit                m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last    = '0;
    m_credits = CREDITS;
    m_sent    = 0;
    m_fin     = 0;
    m_err     = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs against
  // the model, then advance the model across the next rising edge.
  task automatic step(input bit r, input bit v, input logic [63:0] d, input bit tok);
    bit                exp_ready;
    bit                acc;
    logic [BEAT_W-1:0] shown;
    @(negedge clk);
    rst                  = r;
    link_if.core_valid_in = v;
    link_if.core_data_in  = d;
    link_if.io_token      = tok;
    #1;
    exp_ready = !r && (exp_q.size() == 0) && (m_credits != 0);
    shown     = (exp_q.size() != 0) ? exp_q[0] : m_last;
    check("ready", 64'(link_if.core_ready_out), 64'(exp_ready));
    check("valid", 64'(link_if.io_valid_out), 64'(exp_q.size() != 0));
    check("data", 64'(link_if.io_data_out), 64'(shown));
    check("sent_cnt", 64'(sent_cnt), 64'(m_sent % (1 << CNT_W)));
    check("finish_cnt", 64'(finish_cnt), 64'(m_fin % (1 << CNT_W)));
    check("credit_cnt", 64'(credit_cnt), 64'(m_credits));
    check("credit_err", 64'(credit_err), 64'(m_err));
`ifdef BSG_UPOUT_PARITY_EN
    begin
      logic [CHANNELS-1:0] exp_par;
      for (int c = 0; c < CHANNELS; c++) exp_par[c] = ^shown[c*CH_W +: CH_W];
      check("parity", 64'(link_if.io_parity_out), 64'(exp_par));
    end
`endif
    if (r) begin
      model_reset();
    end else begin
      acc = v && exp_ready;
      if (exp_q.size() != 0) begin
        m_last = exp_q.pop_front();
        if (exp_q.size() == 0) m_fin++;
      end
      if (acc) begin
        for (int b = 0; b < BEATS; b++) exp_q.push_back(d[b*BEAT_W +: BEAT_W]);
        m_sent++;
      end
      if (tok && !acc) begin
        if (m_credits == CREDITS) m_err = 1'b1;
        else m_credits++;
      end else if (acc && !tok) begin
        m_credits--;
      end
    end
    @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < BEATS + 1; i++) step(1'b0, 1'b0, 64'h0, 1'b0);
  endtask

  initial begin
    logic [15:0] t1_beats [4];
    logic [63:0] w;
    int          n;
    int          prev_sent;

    t1_beats[0] = 16'h0100;
    t1_beats[1] = 16'h0302;
    t1_beats[2] = 16'h0504;
    t1_beats[3] = 16'h0706;

    // Reset and reset-state checks
    rst                   = 1'b1;
    link_if.core_valid_in = 1'b0;
    link_if.core_data_in  = '0;
    link_if.io_token      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(link_if.core_ready_out), 64'd0);
    check("rst_valid", 64'(link_if.io_valid_out), 64'd0);
    check("rst_data", 64'(link_if.io_data_out), 64'd0);
    check("rst_sent", 64'(sent_cnt), 64'd0);
    check("rst_finish", 64'(finish_cnt), 64'd0);
    check("rst_credit", 64'(credit_cnt), 64'd4);
    check("rst_err", 64'(credit_err), 64'd0);
`ifdef BSG_UPOUT_PARITY_EN
    check("rst_parity", 64'(link_if.io_parity_out), 64'd0);
`endif
    model_reset();

    // T1: single word, beats in order
    step(1'b0, 1'b1, 64'h0706050403020100, 1'b0);
    for (int b = 0; b < 4; b++) begin
      #1;
      check("t1_beat", 64'(link_if.io_data_out), 64'(t1_beats[b]));
`ifdef BSG_UPOUT_PARITY_EN
      if (b == 0) check("t1_parity", 64'(link_if.io_parity_out), 64'b10);
`endif
      step(1'b0, 1'b0, 64'h0, 1'b0);
    end
    #1;
    check("t1_sent", 64'(sent_cnt), 64'd1);
    check("t1_finish", 64'(finish_cnt), 64'd1);
    check("t1_credit", 64'(credit_cnt), 64'd3);

    // T2: restore full credits, then hold valid with no tokens
    step(1'b0, 1'b0, 64'h0, 1'b1);
    w = {$urandom(), $urandom()};
    for (int i = 0; i < 25; i++) begin
      prev_sent = m_sent;
      step(1'b0, 1'b1, w, 1'b0);
      if (m_sent != prev_sent) w = {$urandom(), $urandom()};
    end
    #1;
    check("t2_sent4", 64'(sent_cnt), 64'd5);
    check("t2_credit0", 64'(credit_cnt), 64'd0);
    check("t2_ready0", 64'(link_if.core_ready_out), 64'd0);
    step(1'b0, 1'b1, w, 1'b1);
    step(1'b0, 1'b1, w, 1'b0);
    #1;
    check("t2_fifth", 64'(sent_cnt), 64'd6);
    check("t2_credit_back0", 64'(credit_cnt), 64'd0);
    drain();

    // T3: token and accept on the same cycle at credit 2
    step(1'b0, 1'b0, 64'h0, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    step(1'b0, 1'b1, {$urandom(), $urandom()}, 1'b1);
    #1;
    check("t3_credit", 64'(credit_cnt), 64'd2);
    drain();

    // T4: overflow token in IDLE
    step(1'b0, 1'b0, 64'h0, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    #1;
    check("t4_credit", 64'(credit_cnt), 64'd4);
    check("t4_err", 64'(credit_err), 64'd1);
    step(1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b0);

    // T5: reset during beat 2 aborts the word
    step(1'b1, 1'b0, 64'h0, 1'b0);
    step(1'b0, 1'b1, {$urandom(), $urandom()}, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b1, 1'b0, 64'h0, 1'b0);
    #1;
    check("t5_valid", 64'(link_if.io_valid_out), 64'd0);
    check("t5_credit", 64'(credit_cnt), 64'd4);
    check("t5_finish", 64'(finish_cnt), 64'd0);
    w = {$urandom(), $urandom()};
    step(1'b0, 1'b1, w, 1'b0);
    #1;
    check("t5_beat0", 64'(link_if.io_data_out), 64'(w[15:0]));
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), {$urandom(), $urandom()},
           ($urandom_range(0, 3) == 0));
    end
    drain();

    // T6: counter wrap after 128 words
    step(1'b1, 1'b0, 64'h0, 1'b0);
    n = 0;
    while (m_sent < 128 && n < 1000) begin
      step(1'b0, 1'b1, {$urandom(), $urandom()}, 1'b1);
      n++;
    end
    #1;
    check("t6_model_words", 64'(m_sent), 64'd128);
    check("t6_sent_wrap", 64'(sent_cnt), 64'd0);
    drain();
    #1;
    check("t6_finish_wrap", 64'(finish_cnt), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
